// File: rtl/settle_timer_pkg.sv
// Shared constants and elaboration helpers for the settle/lock-wait timer bank.
package settle_timer_pkg;

    localparam int MODE_ONESHOT  = 0;
    localparam int MODE_PERIODIC = 1;

    localparam int unsigned DEFAULT_TERMINAL = 1600;

    // A terminal of 0 is reserved to mean "use the default", so it is never a legal default.
    function automatic bit terminal_legal(input longint unsigned t, input int w);
        return (t >= 64'd1) && (t <= ((64'd1 << w) - 64'd1));
    endfunction

endpackage

// File: rtl/settle_timer_ch.sv
// One settle-timer channel: counts while enabled, flags and pulses on reaching its terminal.
module settle_timer_ch
    import settle_timer_pkg::*;
#(
    parameter int          WIDTH    = 12,
    parameter int unsigned TERMINAL = DEFAULT_TERMINAL,
    parameter int          PERIODIC = MODE_ONESHOT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             status,
    output logic             done_pulse
);

    localparam logic [WIDTH-1:0] TC_DEFAULT = TERMINAL[WIDTH-1:0];

    if (!terminal_legal(longint'(TERMINAL), WIDTH)) begin : g_bad_terminal
        $error("settle_timer_ch: TERMINAL out of range 1..2^WIDTH-1");
    end

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] term_q_reg, term_q_next;
    logic             status_d_reg;
    logic [WIDTH-1:0] tc;

    assign tc = (term_q_reg == '0) ? TC_DEFAULT : term_q_reg;

    // The terminal is only sampled while idle, so edits during a count are ignored.
    always_comb begin
        cnt_next    = cnt_reg;
        term_q_next = term_q_reg;
        if (!en) begin
            cnt_next    = '0;
            term_q_next = term;
        end else if (cnt_reg != tc) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (PERIODIC == MODE_PERIODIC) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            term_q_reg   <= '0;
            status_d_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            term_q_reg   <= term_q_next;
            status_d_reg <= status;
        end
    end

    assign status     = (cnt_reg == tc);
    assign done_pulse = status & ~status_d_reg;

endmodule

// File: rtl/settle_timer_bank.sv
// Bank of independent settle timers with registered all/any-done aggregation.
module settle_timer_bank
    import settle_timer_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          WIDTH    = 12,
    parameter int unsigned TERMINAL = DEFAULT_TERMINAL,
    parameter int          PERIODIC = MODE_ONESHOT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] term,
    output logic [CHANNELS-1:0]       status,
    output logic [CHANNELS-1:0]       done_pulse,
    output logic                      all_done,
    output logic                      any_done
);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("settle_timer_bank: CHANNELS must be 1..16");
    end

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("settle_timer_bank: WIDTH must be 2..32");
    end

    logic all_done_reg;
    logic any_done_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        settle_timer_ch #(
            .WIDTH    (WIDTH),
            .TERMINAL (TERMINAL),
            .PERIODIC (PERIODIC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en[gi]),
            .term       (term[gi*WIDTH +: WIDTH]),
            .status     (status[gi]),
            .done_pulse (done_pulse[gi])
        );
    end

    // Aggregates lag status by one cycle so downstream sequencing sees clean registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            all_done_reg <= 1'b0;
            any_done_reg <= 1'b0;
        end else begin
            all_done_reg <= &status;
            any_done_reg <= |status;
        end
    end

    assign all_done = all_done_reg;
    assign any_done = any_done_reg;

endmodule
